// File: rtl/issue_unit.sv
// issue_unit: single-issue dispatcher with register-status renaming and CDB bypass
module issue_unit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Instr_valid,
  input  logic [15:0] Instr,
  output logic        Instr_ready,
  output logic [2:0]  Rf_addr_s,
  output logic [2:0]  Rf_addr_t,
  input  logic [15:0] Rf_data_s,
  input  logic [15:0] Rf_data_t,
  input  logic [2:0]  Rs_busy,
  input  logic        Cdb_valid,
  input  logic [2:0]  Cdb_tag,
  input  logic [15:0] Cdb_value,
  output logic [2:0]  Opcode,
  output logic [15:0] Vj,
  output logic [15:0] Vk,
  output logic [2:0]  Qj,
  output logic [2:0]  Qk,
  output logic [2:0]  Enable_VQ
);
  typedef enum logic [1:0] {IDLE, ISSUE, STALL} state_t;
  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d, vj_q, vj_d, vk_q, vk_d;
  logic [2:0]  rst_q [8];
  logic [2:0]  rst_d [8];
  logic [2:0]  en_q, en_d, op_q, op_d, qj_q, qj_d, qk_q, qk_d;
  logic [2:0]  free, sel_tag, tag_s, tag_t;
  logic        byp_s, byp_t, issue;
  assign Instr_ready = state_q == IDLE;
  assign Rf_addr_s   = ir_q[9:7];
  assign Rf_addr_t   = ir_q[6:4];
  assign Opcode      = op_q;
  assign Vj          = vj_q;
  assign Vk          = vk_q;
  assign Qj          = qj_q;
  assign Qk          = qk_q;
  assign Enable_VQ   = en_q;
  always_comb begin
    free    = ~Rs_busy & ~en_q;
    sel_tag = free[0] ? 3'd1 : free[1] ? 3'd2 : free[2] ? 3'd3 : 3'd0;
    issue   = state_q != IDLE && sel_tag != 3'd0;
    tag_s   = rst_q[ir_q[9:7]];
    tag_t   = rst_q[ir_q[6:4]];
    byp_s   = Cdb_valid && Cdb_tag == tag_s;
    byp_t   = Cdb_valid && Cdb_tag == tag_t;
  end
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    en_d    = 3'd0;
    op_d    = op_q;
    vj_d    = vj_q;
    vk_d    = vk_q;
    qj_d    = qj_q;
    qk_d    = qk_q;
    for (int i = 0; i < 8; i++)
      rst_d[i] = (Cdb_valid && Cdb_tag != 3'd0 && rst_q[i] == Cdb_tag) ? 3'd0 : rst_q[i];
    if (state_q == IDLE) begin
      if (Instr_valid) begin
        ir_d    = Instr;
        state_d = ISSUE;
      end
    end else if (issue) begin
      // operands resolve from the pre-issue table, so Rd==Rs/Rt sees the old producer
      state_d            = IDLE;
      en_d               = {sel_tag == 3'd3, sel_tag == 3'd2, sel_tag == 3'd1};
      op_d               = ir_q[15:13];
      vj_d               = tag_s == 3'd0 ? Rf_data_s : byp_s ? Cdb_value : 16'd0;
      vk_d               = tag_t == 3'd0 ? Rf_data_t : byp_t ? Cdb_value : 16'd0;
      qj_d               = (tag_s == 3'd0 || byp_s) ? 3'd0 : tag_s;
      qk_d               = (tag_t == 3'd0 || byp_t) ? 3'd0 : tag_t;
      rst_d[ir_q[12:10]] = sel_tag;
    end else begin
      state_d = STALL;
    end
  end
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      ir_q    <= 16'd0;
      en_q    <= 3'd0;
      op_q    <= 3'd0;
      vj_q    <= 16'd0;
      vk_q    <= 16'd0;
      qj_q    <= 3'd0;
      qk_q    <= 3'd0;
      for (int i = 0; i < 8; i++) rst_q[i] <= 3'd0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      en_q    <= en_d;
      op_q    <= op_d;
      vj_q    <= vj_d;
      vk_q    <= vk_d;
      qj_q    <= qj_d;
      qk_q    <= qk_d;
      for (int i = 0; i < 8; i++) rst_q[i] <= rst_d[i];
    end
  end
endmodule

// File: tb/tb_issue_unit.sv
// tb_issue_unit: directed scenarios plus random traffic against a pending-instruction reference model
module tb_issue_unit;
  logic        Clock = 0, Reset = 0, Instr_valid = 0, Cdb_valid = 0;
  logic [15:0] Instr = 0, Rf_data_s = 0, Rf_data_t = 0, Cdb_value = 0;
  logic [2:0]  Rs_busy = 0, Cdb_tag = 0;
  logic        Instr_ready;
  logic [2:0]  Rf_addr_s, Rf_addr_t, Opcode, Qj, Qk, Enable_VQ;
  logic [15:0] Vj, Vk;
  int n_tests = 0, n_fail = 0;
  bit          pend;
  logic [15:0] mir, mvj, mvk;
  logic [2:0]  mrst [8];
  logic [2:0]  men, mop, mqj, mqk;

  issue_unit dut (
    .Clock(Clock), .Reset(Reset), .Instr_valid(Instr_valid), .Instr(Instr),
    .Instr_ready(Instr_ready), .Rf_addr_s(Rf_addr_s), .Rf_addr_t(Rf_addr_t),
    .Rf_data_s(Rf_data_s), .Rf_data_t(Rf_data_t), .Rs_busy(Rs_busy),
    .Cdb_valid(Cdb_valid), .Cdb_tag(Cdb_tag), .Cdb_value(Cdb_value),
    .Opcode(Opcode), .Vj(Vj), .Vk(Vk), .Qj(Qj), .Qk(Qk), .Enable_VQ(Enable_VQ)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [18:0] resolve(input logic [2:0] tag, input logic [15:0] rf);
    if (tag == 0) return {rf, 3'd0};
    if (Cdb_valid && Cdb_tag == tag) return {Cdb_value, 3'd0};
    return {16'd0, tag};
  endfunction

  task automatic m_reset;
    pend = 0; mir = 0; men = 0; mop = 0; mvj = 0; mvk = 0; mqj = 0; mqk = 0;
    for (int i = 0; i < 8; i++) mrst[i] = 0;
  endtask

  task automatic model_edge;
    logic [2:0] t, nrst [8];
    t = 0;
    for (int i = 3; i >= 1; i--) if (!Rs_busy[i-1] && !men[i-1]) t = 3'(i);
    for (int i = 0; i < 8; i++)
      nrst[i] = (Cdb_valid && Cdb_tag != 0 && mrst[i] == Cdb_tag) ? 3'd0 : mrst[i];
    men = 0;
    if (!pend) begin
      if (Instr_valid) begin pend = 1; mir = Instr; end
    end else if (t != 0) begin
      {mvj, mqj} = resolve(mrst[mir[9:7]], Rf_data_s);
      {mvk, mqk} = resolve(mrst[mir[6:4]], Rf_data_t);
      mop = mir[15:13];
      men = 3'd1 << (t - 1);
      nrst[mir[12:10]] = t;
      pend = 0;
    end
    mrst = nrst;
  endtask

  task automatic compare_all;
    check("ready", 16'(Instr_ready), 16'(!pend));
    check("en", 16'(Enable_VQ), 16'(men));
    check("addr_s", 16'(Rf_addr_s), 16'(mir[9:7]));
    check("addr_t", 16'(Rf_addr_t), 16'(mir[6:4]));
    check("opcode", 16'(Opcode), 16'(mop));
    check("vj", Vj, mvj);
    check("vk", Vk, mvk);
    check("qj", 16'(Qj), 16'(mqj));
    check("qk", 16'(Qk), 16'(mqk));
  endtask

  task automatic step;
    @(posedge Clock);
    if (Reset) model_edge();
    #1 compare_all();
    @(negedge Clock);
  endtask

  function automatic logic [15:0] mk(input int op, rd, rs, rt);
    return {3'(op), 3'(rd), 3'(rs), 3'(rt), 4'd0};
  endfunction

  task automatic issue2(input logic [15:0] ins, input logic [2:0] busy);
    Instr = ins; Instr_valid = 1; Rs_busy = busy;
    step();
    Instr_valid = 0;
    step();
  endtask

  initial begin
    m_reset();
    #1 compare_all();
    check("reset_en", 16'(Enable_VQ), 16'd0);
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1;
    // simple issue: ADD r1,r2,r3
    Rf_data_s = 16'd5; Rf_data_t = 16'd7;
    issue2(mk(0, 1, 2, 3), 3'b000);
    check("simple_en", 16'(Enable_VQ), 16'h1);
    check("simple_vj", Vj, 16'd5);
    check("simple_vk", Vk, 16'd7);
    check("simple_qj", 16'(Qj), 16'd0);
    // dependency: SUB r4,r1,r2
    issue2(mk(1, 4, 1, 2), 3'b001);
    check("dep_en", 16'(Enable_VQ), 16'h2);
    check("dep_qj", 16'(Qj), 16'd1);
    check("dep_vj", Vj, 16'd0);
    check("dep_qk", 16'(Qk), 16'd0);
    // CDB bypass of r1 in the issue cycle
    Instr = mk(2, 5, 1, 4); Instr_valid = 1; Rs_busy = 3'b011;
    step();
    Instr_valid = 0; Cdb_valid = 1; Cdb_tag = 3'd1; Cdb_value = 16'h00AA;
    step();
    Cdb_valid = 0;
    check("byp_vj", Vj, 16'h00AA);
    check("byp_qj", 16'(Qj), 16'd0);
    check("byp_qk", 16'(Qk), 16'd2);
    check("byp_en", 16'(Enable_VQ), 16'h4);
    // stall with all stations busy, then station 2 frees
    Instr = mk(3, 4, 1, 5); Instr_valid = 1; Rs_busy = 3'b111; Rf_data_s = 16'h0033;
    step();
    Instr_valid = 0;
    step();
    check("stall_en", 16'(Enable_VQ), 16'd0);
    check("stall_ready", 16'(Instr_ready), 16'd0);
    step();
    Rs_busy = 3'b101;
    step();
    check("unstall_en", 16'(Enable_VQ), 16'h2);
    check("unstall_qj", 16'(Qj), 16'd0);
    check("unstall_vj", Vj, 16'h0033);
    check("unstall_qk", 16'(Qk), 16'd3);
    // write-after-clear on r4 (producer 2 broadcasts while r4 is renamed to 3)
    Instr = mk(4, 4, 4, 0); Instr_valid = 1; Rs_busy = 3'b011;
    step();
    Instr_valid = 0; Cdb_valid = 1; Cdb_tag = 3'd2; Cdb_value = 16'h1234;
    step();
    Cdb_valid = 0;
    check("wac_vj", Vj, 16'h1234);
    check("wac_en", 16'(Enable_VQ), 16'h4);
    issue2(mk(5, 1, 4, 4), 3'b000);
    check("wac_qj", 16'(Qj), 16'd3);
    check("wac_qk", 16'(Qk), 16'd3);
    // reset while stalled
    Instr = mk(6, 2, 4, 5); Instr_valid = 1; Rs_busy = 3'b111;
    step();
    Instr_valid = 0;
    step();
    Reset = 0;
    #1 m_reset();
    compare_all();
    check("rst_ready", 16'(Instr_ready), 16'd1);
    step();
    Reset = 1; Rs_busy = 3'b000;
    step();
    check("rst_no_pulse", 16'(Enable_VQ), 16'd0);
    issue2(mk(7, 3, 4, 5), 3'b000);
    check("rst_rst_qj", 16'(Qj), 16'd0);
    check("rst_rst_qk", 16'(Qk), 16'd0);
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      Instr_valid = ($urandom_range(0, 3) != 0);
      Instr       = 16'($urandom);
      Rs_busy     = ($urandom_range(0, 3) == 0) ? 3'b111 : 3'($urandom);
      Cdb_valid   = $urandom_range(0, 1) == 1;
      Cdb_tag     = 3'($urandom_range(0, 3));
      Cdb_value   = 16'($urandom);
      Rf_data_s   = 16'($urandom);
      Rf_data_t   = 16'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        Reset = 0;
        #1 m_reset();
        compare_all();
        step();
        Reset = 1;
      end else begin
        step();
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
